// File: rtl/alu_exec_stage.sv
// ---------------------------------------------------------------------------
// alu_exec_stage
// Registered execute stage for the RV32I core. Computes the ALU result and
// zero flag for the operation offered by decode and buffers it in a 2-entry
// FIFO with valid/ready handshakes on both sides.
//
// Ports:
//   clk, rst         core clock; synchronous active-high reset
//   flush            drop all buffered entries and this cycle's offered op
//   id_valid/ready   decode-side handshake (id_ready from registered count)
//   id_alu_control   000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT
//   id_src_a/b       operands
//   id_rd            destination register
//   id_reg_write     writeback enable carried with the op
//   ex_valid/ready   downstream handshake on the FIFO head
//   ex_result        head ALU result (0 when empty)
//   ex_zero          head result == 0 (0 when empty)
//   ex_rd            head destination (0 when empty)
//   ex_reg_write     head writeback enable (0 when empty)
//   ex_illegal       head carried an undefined control code (0 when empty)
// ---------------------------------------------------------------------------
module alu_exec_stage #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned RD_W  = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             id_valid,
   output logic             id_ready,
   input  logic [2:0]       id_alu_control,
   input  logic [WIDTH-1:0] id_src_a,
   input  logic [WIDTH-1:0] id_src_b,
   input  logic [RD_W-1:0]  id_rd,
   input  logic             id_reg_write,
   output logic             ex_valid,
   input  logic             ex_ready,
   output logic [WIDTH-1:0] ex_result,
   output logic             ex_zero,
   output logic [RD_W-1:0]  ex_rd,
   output logic             ex_reg_write,
   output logic             ex_illegal
);

   localparam int unsigned CNT_W = 2;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_SLT = 3'b101;

   typedef struct packed {
      logic [WIDTH-1:0] result;
      logic             zero;
      logic [RD_W-1:0]  rd;
      logic             reg_write;
      logic             illegal;
   } entry_t;

   entry_t           slot_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [CNT_W-1:0] count_q;

   logic [WIDTH-1:0] alu_result_c;
   logic             alu_illegal_c;
   entry_t           new_entry_c;
   entry_t           head_c;
   logic             push_c;
   logic             pop_c;

   // ALU: undefined codes yield 0 and are flagged illegal
   always_comb begin
      alu_result_c  = '0;
      alu_illegal_c = 1'b0;
      case (id_alu_control)
         OP_ADD:  alu_result_c = id_src_a + id_src_b;
         OP_SUB:  alu_result_c = id_src_a - id_src_b;
         OP_AND:  alu_result_c = id_src_a & id_src_b;
         OP_OR:   alu_result_c = id_src_a | id_src_b;
         OP_SLT:  alu_result_c = WIDTH'($signed(id_src_a) < $signed(id_src_b));
         default: alu_illegal_c = 1'b1;
      endcase
   end

   // Entry written into the FIFO on a push
   always_comb begin
      new_entry_c           = '0;
      new_entry_c.result    = alu_result_c;
      new_entry_c.zero      = (alu_result_c == '0);
      new_entry_c.rd        = id_rd;
      new_entry_c.reg_write = id_reg_write;
      new_entry_c.illegal   = alu_illegal_c;
   end

   // Handshakes; id_ready depends only on the registered count
   assign id_ready = (count_q < CNT_W'(2));
   assign ex_valid = (count_q != '0);
   assign push_c   = id_valid && id_ready && !flush;
   assign pop_c    = ex_valid && ex_ready;

   // FIFO state; flush wins over push/pop, reset wins over flush
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_q[0] <= '0;
         slot_q[1] <= '0;
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         count_q   <= '0;
      end else if (flush) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= '0;
      end else begin
         if (push_c) begin
            slot_q[wr_ptr_q] <= new_entry_c;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop_c) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({push_c, pop_c})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Head slot drives the outputs, forced to 0 while empty
   always_comb begin
      head_c = '0;
      if (ex_valid) begin
         head_c = slot_q[rd_ptr_q];
      end
   end

   assign ex_result    = head_c.result;
   assign ex_zero      = head_c.zero;
   assign ex_rd        = head_c.rd;
   assign ex_reg_write = head_c.reg_write;
   assign ex_illegal   = head_c.illegal;

endmodule
